gray_serial_sched: RTL and testbench

Two-requester scheduler and sequencer for a bit-serial Gray-to-binary conversion path. It arbitrates round-robin between two 5-bit Gray-code word sources and loads the winner into an internal parallel-to-serial register. It runs the MSB-first serial XOR conversion for exactly WIDTH shift cycles, then presents the binary word with a one-cycle valid pulse and the source ID. It sits where the existing free-running PISO -> FSM -> SIPO chain sits, and adds framing, per-word state reset and resource sharing.

---
 rtl/gray_serial_sched.sv | 122 ++++++++++++
 tb/tb_gray_serial_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_serial_sched.sv
// gray_serial_sched: two-requester round-robin scheduler feeding a shared
// bit-serial, MSB-first Gray-to-binary converter. One word is accepted in
// IDLE, shifted for WIDTH cycles, then presented for a single DONE cycle.
module gray_serial_sched #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] din0,
    input  logic             req1,
    input  logic [WIDTH-1:0] din1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             dout_id
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    logic [1:0]       state_q;
    logic             rr_ptr_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] res_q;
    logic             acc_q;
    logic [CW-1:0]    cnt_q;
    logic             id_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_id_q;

    logic             win;
    logic             bit_b;
    logic             cnt_last;
    logic [WIDTH-1:0] res_next;

    // Arbitration: a lone requester wins outright, a tie goes to rr_ptr.
    // Grants are suppressed while reset is being applied.
    always_comb begin
        win = 1'b0;
        gnt = 2'b00;
        if (state_q == StIdle && !rst) begin
            if (req0 && req1) begin
                win = rr_ptr_q;
            end else if (req1) begin
                win = 1'b1;
            end else begin
                win = 1'b0;
            end
            if (req0 || req1) begin
                gnt = win ? 2'b10 : 2'b01;
            end
        end
    end

    // Serial conversion datapath: each binary bit is the running XOR of Gray bits.
    always_comb begin
        bit_b    = acc_q ^ sreg_q[WIDTH-1];
        res_next = {res_q[WIDTH-2:0], bit_b};
        cnt_last = (cnt_q == CW'(WIDTH - 1));
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy       = (state_q == StShift) || (state_q == StDone);
        dout_valid = (state_q == StDone) && !rst;
        dout       = dout_q;
        dout_id    = dout_id_q;
    end

    // Sequencer and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            rr_ptr_q  <= 1'b0;
            sreg_q    <= '0;
            res_q     <= '0;
            acc_q     <= 1'b0;
            cnt_q     <= '0;
            id_q      <= 1'b0;
            dout_q    <= '0;
            dout_id_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (gnt != 2'b00) begin
                        sreg_q   <= win ? din1 : din0;
                        res_q    <= '0;
                        acc_q    <= 1'b0;
                        cnt_q    <= '0;
                        id_q     <= win;
                        rr_ptr_q <= ~win;
                        state_q  <= StShift;
                    end
                end
                StShift: begin
                    acc_q  <= bit_b;
                    res_q  <= res_next;
                    sreg_q <= sreg_q << 1;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_last) begin
                        // Publish on the last shift edge so DONE sees the result.
                        dout_q    <= res_next;
                        dout_id_q <= id_q;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_serial_sched.sv
// Bench for gray_serial_sched: directed scenarios plus random traffic, checked
// by a scoreboard fed from a cycle-level reference model.
module tb_gray_serial_sched;

    localparam int unsigned W = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0;
    logic [W-1:0] din0 = '0;
    logic         req1 = 1'b0;
    logic [W-1:0] din1 = '0;
    logic [1:0]   gnt;
    logic         busy;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_id;

    gray_serial_sched #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .din0       (din0),
        .req1       (req1),
        .din1       (din1),
        .gnt        (gnt),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_id    (dout_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         id;
        int           due;
    } exp_t;

    exp_t         sb_q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    logic [1:0]   g_seen = 2'b00;
    logic         hold = 1'b0;

    // Reference model state
    logic         m_rr = 1'b0;
    int           m_free = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Model: grant decision, busy window and expected result per accepted word.
    always @(negedge clk) begin
        logic       idle;
        logic       w;
        logic [1:0] eg;
        if (rst) begin
            m_rr   = 1'b0;
            m_free = cyc + 1;
            chk("gnt_rst", {30'd0, gnt}, 32'd0);
        end else begin
            idle = (cyc >= m_free);
            eg   = 2'b00;
            w    = 1'b0;
            if (idle && (req0 || req1)) begin
                w  = (req0 && req1) ? m_rr : req1;
                eg = w ? 2'b10 : 2'b01;
            end
            chk("gnt", {30'd0, gnt}, {30'd0, eg});
            chk("busy", {31'd0, busy}, {31'd0, !idle});
            if (eg != 2'b00) begin
                sb_q.push_back('{d: gray2bin(w ? din1 : din0), id: w, due: cyc + W + 1});
                m_rr   = ~w;
                m_free = cyc + W + 2;
            end
        end
    end

    // Monitor: pops the expected word when the DUT should be presenting it.
    logic [W-1:0] last_d = '0;
    logic         last_id = 1'b0;
    always @(negedge clk) begin
        logic ev;
        exp_t e;
        if (rst) begin
            sb_q.delete();
            last_d  = '0;
            last_id = 1'b0;
        end else begin
            ev = (sb_q.size() > 0) && (sb_q[0].due == cyc);
            chk("dout_valid", {31'd0, dout_valid}, {31'd0, ev});
            if (ev) begin
                e       = sb_q.pop_front();
                last_d  = e.d;
                last_id = e.id;
            end
            chk("dout", {27'd0, dout}, {27'd0, last_d});
            chk("dout_id", {31'd0, dout_id}, {31'd0, last_id});
        end
    end

    // Advance one cycle; granted requesters drop req unless told to hold.
    task automatic tick();
        @(negedge clk);
        g_seen = gnt;
        @(posedge clk);
        #1;
        if (!hold) begin
            if (g_seen[0]) req0 = 1'b0;
            if (g_seen[1]) req1 = 1'b0;
        end
    endtask

    logic [W-1:0] bvals [3];

    initial begin
        bvals[0] = 5'b00000;
        bvals[1] = 5'b10000;
        bvals[2] = 5'b11111;

        // Reset, then idle
        tick();
        tick();
        rst = 1'b0;
        repeat (10) tick();

        // Single word, with absolute result check
        req0 = 1'b1;
        din0 = 5'b01101;
        tick();
        repeat (5) tick();
        @(negedge clk);
        chk("single_abs", {27'd0, dout}, {27'd0, 5'b01001});
        @(posedge clk);
        #1;
        repeat (3) tick();

        // Boundary values through requester 1
        for (int i = 0; i < 3; i++) begin
            req1 = 1'b1;
            din1 = bvals[i];
            tick();
            repeat (7) tick();
        end

        // Contention: both held high, grants must alternate
        hold = 1'b1;
        req0 = 1'b1;
        din0 = 5'b00001;
        req1 = 1'b1;
        din1 = 5'b00011;
        repeat (30) tick();
        hold = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (8) tick();

        // Mid-operation reset: grant to 0, reset in SHIFT, then tie must go to 0
        req0 = 1'b1;
        din0 = W'($urandom);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        req0 = 1'b1;
        req1 = 1'b1;
        din0 = W'($urandom);
        din1 = W'($urandom);
        repeat (20) tick();
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (8) tick();

        // Inputs wiggling while busy must not disturb the granted word
        req0 = 1'b1;
        din0 = 5'b10110;
        tick();
        for (int i = 0; i < 4; i++) begin
            din0 = W'($urandom);
            req1 = 1'b1;
            din1 = W'($urandom);
            tick();
        end
        repeat (12) tick();

        // Random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if (!req0 && ($urandom % 3 == 0)) begin
                req0 = 1'b1;
                din0 = W'($urandom);
            end else if (req0 && ($urandom % 4 == 0)) begin
                din0 = W'($urandom);
            end
            if (!req1 && ($urandom % 3 == 0)) begin
                req1 = 1'b1;
                din1 = W'($urandom);
            end else if (req1 && ($urandom % 4 == 0)) begin
                din1 = W'($urandom);
            end
            rst = ($urandom % 200 == 0);
            tick();
        end
        rst  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
